final_soc_pio_in_edge: RTL and testbench



---
 rtl/final_soc_pio_in_edge.sv | 136 +++++++++++++
 tb/tb_final_soc_pio_in_edge.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/final_soc_pio_in_edge.sv
// Avalon-MM input PIO for buttons/switches: per-bit synchroniser, debounce,
// edge capture with write-1-to-clear, and a maskable level interrupt.
module final_soc_pio_in_edge #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_db;
    logic [WIDTH-1:0] r_db_d;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic             w_wr_mask;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    // Upper write-data bits beyond WIDTH carry no meaning for this port.
    assign w_unused = &{1'b0, writedata};

    // Multi-flop synchroniser chain per input bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            // Debounce bypassed: accept the synchronised level every cycle.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) r_db <= '0;
                else          r_db <= w_s;
            end
        end else begin : g_deb
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
            logic [CNT_W-1:0] r_cnt [WIDTH];

            // Per-bit persistence counter; a new level is accepted only after
            // it has differed from the debounced level for DEBOUNCE_CYCLES cycles.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_db <= '0;
                    for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (w_s[i] == r_db[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_db[i]  <= w_s[i];
                            r_cnt[i] <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_db_d <= '0;
        else          r_db_d <= r_db;
    end

    // Select which transition counts as an event.
    always_comb begin
        w_det = '0;
        case (EDGE_TYPE)
            0:       w_det = r_db & ~r_db_d;
            1:       w_det = ~r_db & r_db_d;
            default: w_det = r_db ^ r_db_d;
        endcase
    end

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_mask = w_wr && (address == 2'd2);
    assign w_clr     = (w_wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_irq_mask <= '0;
        else if (w_wr_mask) r_irq_mask <= writedata[WIDTH-1:0];
    end

    // Edge capture: a new event in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_edge <= '0;
        else          r_edge <= (r_edge & ~w_clr) | w_det;
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux[WIDTH-1:0] = r_db;
            2'd2:    w_rd_mux[WIDTH-1:0] = r_irq_mask;
            2'd3:    w_rd_mux[WIDTH-1:0] = r_edge;
            default: w_rd_mux = '0;
        endcase
    end

    // Read data registered every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_readdata <= '0;
        else          r_readdata <= w_rd_mux;
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge & r_irq_mask);

endmodule

// File: tb/tb_final_soc_pio_in_edge.sv
// Directed bench for final_soc_pio_in_edge: one rising-edge instance and one
// any-edge instance sharing the bus.
module tb_final_soc_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [3:0]  in_port2;
    logic [31:0] readdata;
    logic [31:0] readdata2;
    logic        irq;
    logic        irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    final_soc_pio_in_edge #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    final_soc_pio_in_edge #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port2),
        .readdata(readdata2), .irq(irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; in_port = 4'b0000; in_port2 = 4'b0000;
        address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        #2;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_readdata2", readdata2, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = a[1:0];
            tick();
            check($sformatf("rd_after_rst_a%0d", a), readdata, 32'h0);
        end

        // Rising edge on bit 0 with mask 0001; in_port changes at T0.
        wr(2'd2, 32'h1);
        address = 2'd0;
        tick();
        in_port = 4'b0001;
        repeat (6) tick();
        check("lat_db_T6", readdata, 32'h0);
        check("lat_irq_T6", {31'b0, irq}, 32'h0);
        tick();
        check("lat_db_T7", readdata, 32'h1);
        check("lat_irq_T7", {31'b0, irq}, 32'h1);
        address = 2'd3;
        tick();
        check("lat_edge_T8", readdata, 32'h1);

        // Three-cycle glitch on bit 1 is rejected.
        address = 2'd0;
        in_port = 4'b0011;
        repeat (3) tick();
        in_port = 4'b0001;
        repeat (12) tick();
        check("glitch3_db", readdata, 32'h1);
        address = 2'd3;
        tick();
        check("glitch3_edge", readdata, 32'h1);
        check("glitch3_irq", {31'b0, irq}, 32'h1);

        // Four-cycle pulse on bit 1 is accepted.
        in_port = 4'b0011;
        repeat (4) tick();
        in_port = 4'b0001;
        repeat (14) tick();
        check("pulse4_edge", readdata, 32'h3);
        address = 2'd0;
        tick();
        check("pulse4_db_settled", readdata, 32'h1);

        // Write-1-to-clear bit 0.
        wr(2'd3, 32'h1);
        check("clr_irq_drop", {31'b0, irq}, 32'h0);
        tick();
        check("clr_edge", readdata, 32'h2);

        // New bit-0 rising edge detected in the same cycle as a clear: set wins.
        address = 2'd0;
        in_port = 4'b0000;
        repeat (12) tick();
        check("fall_db", readdata, 32'h0);
        check("fall_irq", {31'b0, irq}, 32'h0);
        in_port = 4'b0001;
        repeat (6) tick();
        address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        check("setwins_irq", {31'b0, irq}, 32'h1);
        tick();
        check("setwins_edge", readdata, 32'h3);

        // Any-edge instance: both transitions captured, masked interrupt.
        wr(2'd2, 32'h0);
        in_port2 = 4'b0100;
        repeat (10) tick();
        check("any_rise_irq_masked", {31'b0, irq2}, 32'h0);
        address = 2'd3;
        tick();
        check("any_rise_edge", readdata2, 32'h4);
        wr(2'd3, 32'h4);
        tick();
        check("any_clr_edge", readdata2, 32'h0);
        in_port2 = 4'b0000;
        repeat (10) tick();
        check("any_fall_edge", readdata2, 32'h4);
        check("any_fall_irq_masked", {31'b0, irq2}, 32'h0);
        wr(2'd2, 32'h4);
        check("any_unmask_irq", {31'b0, irq2}, 32'h1);

        // Reset asserted mid-debounce, bit 3 held high across release.
        wr(2'd2, 32'hF);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        address = 2'd0;
        tick();
        check("pre_rst_db", readdata, 32'h1);
        in_port = 4'b1000;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        check("midrst_readdata2", readdata2, 32'h0);
        check("midrst_irq2", {31'b0, irq2}, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check("rel_db_T6", readdata, 32'h0);
        tick();
        check("rel_db_T7", readdata, 32'h8);
        address = 2'd3;
        tick();
        check("rel_edge", readdata, 32'h8);
        check("rel_irq_masked", {31'b0, irq}, 32'h0);
        address = 2'd2;
        tick();
        check("rel_mask", readdata, 32'h0);
        address = 2'd1;
        tick();
        check("rd_addr1", readdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
